// File: rtl/enemy_spawner_if.sv
// Handshake bundle between the game FSM (master) and the enemy spawner (slave).
interface enemy_spawner_if #(
   parameter int unsigned N_ENEMIES = 4
);
   logic                      start;
   logic                      pause;
   logic                      game_over;
   logic [N_ENEMIES-1:0]      en;
   logic [16*N_ENEMIES-1:0]   control;
   logic [2:0]                level;
   logic                      spawn_pulse;
   logic                      busy;

   modport master (
      output start, pause, game_over,
      input  en, control, level, spawn_pulse, busy
   );

   modport slave (
      input  start, pause, game_over,
      output en, control, level, spawn_pulse, busy
   );
endinterface

// File: rtl/enemy_spawner.sv
// Per-frame enemy slot scheduler: timed spawns, control-word refresh, difficulty ramp,
// pause and game-over handling.
module enemy_spawner #(
   parameter int unsigned N_ENEMIES     = 4,
   parameter int unsigned BASE_INTERVAL = 60,
   parameter int unsigned MIN_INTERVAL  = 16,
   parameter int unsigned INTERVAL_STEP = 8,
   parameter int unsigned LEVEL_FRAMES  = 600,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic           frame_clk,
   input  logic           rst,
   enemy_spawner_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

   state_e                  state_q, state_d;
   logic [7:0]              timer_q, timer_d;
   logic [N_ENEMIES-1:0]    active_mask_q, active_mask_d;
   logic [16*N_ENEMIES-1:0] control_q, control_d;
   logic [2:0]              level_q, level_d;
   logic                    spawn_pulse_q, spawn_pulse_d;
   logic [15:0]             level_cnt_q, level_cnt_d;
   logic [2:0]              refresh_ptr_q, refresh_ptr_d;
   logic [15:0]             lfsr_q, lfsr_d;

   logic [9:0]              gen_col;
   logic [1:0]              lvl_sat;
   logic [15:0]             gen_word;
   logic signed [8:0]       interval_raw, interval_min;
   logic [7:0]              cur_interval;
   logic                    free_found;
   logic [2:0]              free_idx;
   logic                    do_spawn;

   always_comb begin
      gen_col = lfsr_q[9:0];
      if (lfsr_q[9:0] >= 10'd640) gen_col = lfsr_q[9:0] - 10'd640;
      lvl_sat  = (level_q > 3'd3) ? 2'd3 : level_q[1:0];
      gen_word = {3'b000, lvl_sat, lfsr_q[10], gen_col};
   end

   // Signed 9-bit arithmetic so a large level cannot wrap the interval upward.
   assign interval_raw = 9'(BASE_INTERVAL) - 9'(32'(level_q) * INTERVAL_STEP);
   assign interval_min = 9'(MIN_INTERVAL);
   assign cur_interval = (interval_raw < interval_min) ? 8'(MIN_INTERVAL) : interval_raw[7:0];

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int k = N_ENEMIES - 1; k >= 0; k--) begin
         if (!active_mask_q[k]) begin
            free_found = 1'b1;
            free_idx   = 3'(k);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      active_mask_d = active_mask_q;
      control_d     = control_q;
      level_d       = level_q;
      spawn_pulse_d = 1'b0;
      level_cnt_d   = level_cnt_q;
      refresh_ptr_d = refresh_ptr_q;
      do_spawn      = 1'b0;
      lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d       = StRun;
               timer_d       = 8'(BASE_INTERVAL - 1);
               active_mask_d = '0;
               level_d       = '0;
               level_cnt_d   = '0;
            end
         end
         StRun: begin
            if (bus.game_over) begin
               active_mask_d = '0;
               state_d       = StIdle;
            end else if (bus.pause) begin
               state_d = StPause;
            end else begin
               if (timer_q != 8'd0) begin
                  timer_d = timer_q - 8'd1;
               end else begin
                  timer_d  = cur_interval - 8'd1;
                  do_spawn = free_found;
               end
               spawn_pulse_d = do_spawn;
               for (int k = 0; k < N_ENEMIES; k++) begin
                  if (do_spawn && free_idx == 3'(k)) begin
                     active_mask_d[k]     = 1'b1;
                     control_d[16*k +: 16] = gen_word;
                  end
                  if (!do_spawn && refresh_ptr_q == 3'(k) && active_mask_q[k]) begin
                     control_d[16*k +: 16] = gen_word;
                  end
               end
               if (!do_spawn) begin
                  refresh_ptr_d = (refresh_ptr_q == 3'(N_ENEMIES - 1)) ? 3'd0
                                                                      : refresh_ptr_q + 3'd1;
               end
               if (level_cnt_q == 16'(LEVEL_FRAMES - 1)) begin
                  level_cnt_d = '0;
                  if (level_q != 3'd7) level_d = level_q + 3'd1;
               end else begin
                  level_cnt_d = level_cnt_q + 16'd1;
               end
            end
         end
         StPause: begin
            if (bus.game_over) begin
               active_mask_d = '0;
               state_d       = StIdle;
            end else if (!bus.pause) begin
               state_d = StRun;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (rst) begin
         state_q       <= StIdle;
         timer_q       <= '0;
         active_mask_q <= '0;
         control_q     <= '0;
         level_q       <= '0;
         spawn_pulse_q <= 1'b0;
         level_cnt_q   <= '0;
         refresh_ptr_q <= '0;
         lfsr_q        <= LFSR_SEED;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         active_mask_q <= active_mask_d;
         control_q     <= control_d;
         level_q       <= level_d;
         spawn_pulse_q <= spawn_pulse_d;
         level_cnt_q   <= level_cnt_d;
         refresh_ptr_q <= refresh_ptr_d;
         lfsr_q        <= lfsr_d;
      end
   end

   assign bus.en          = (state_q == StRun) ? active_mask_q : '0;
   assign bus.busy        = (state_q != StIdle);
   assign bus.control     = control_q;
   assign bus.level       = level_q;
   assign bus.spawn_pulse = spawn_pulse_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Directed bench for enemy_spawner: spawn timing, saturation/refresh, difficulty, pause,
// game over and mid-run reset.
module tb_enemy_spawner;

   logic frame_clk = 1'b0;
   logic rst       = 1'b1;

   always #5 frame_clk = ~frame_clk;

   enemy_spawner_if #(.N_ENEMIES(4)) bus ();
   enemy_spawner_if #(.N_ENEMIES(8)) bus2 ();

   enemy_spawner #(.N_ENEMIES(4)) dut (
      .frame_clk (frame_clk),
      .rst       (rst),
      .bus       (bus)
   );

   // Wide, fast-levelling instance so interval shrinkage is visible before saturation.
   enemy_spawner #(.N_ENEMIES(8), .LEVEL_FRAMES(100)) dut2 (
      .frame_clk (frame_clk),
      .rst       (rst),
      .bus       (bus2)
   );

   assign bus2.start     = bus.start;
   assign bus2.pause     = 1'b0;
   assign bus2.game_over = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int t     = 0;
   int cyc   = 0;
   int p2[$];

   always @(posedge frame_clk) cyc <= cyc + 1;
   always @(negedge frame_clk) if (bus2.spawn_pulse && p2.size() < 5) p2.push_back(cyc);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      #1;
      t++;
   endtask

   task automatic step_to(input int target);
      while (t < target) tick();
   endtask

   task automatic wait_pulse(output int at);
      at = -1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.spawn_pulse) begin
            at = t;
            break;
         end
      end
   endtask

   int t0, t1, t3, at, npulse;
   logic [63:0] snap, prev;
   logic [3:0]  changed;

   initial begin
      bus.start     = 1'b0;
      bus.pause     = 1'b0;
      bus.game_over = 1'b0;
      rst           = 1'b1;
      tick();
      tick();
      check("rst_en", 64'(bus.en), 64'h0);
      check("rst_busy", 64'(bus.busy), 64'h0);
      check("rst_level", 64'(bus.level), 64'h0);
      check("rst_pulse", 64'(bus.spawn_pulse), 64'h0);
      check("rst_control", bus.control, 64'h0);
      rst = 1'b0;
      tick();

      // First run: spawns every 60 frames at level 0
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      t0 = t;
      check("run_busy", 64'(bus.busy), 64'h1);
      wait_pulse(at);
      check("spawn1_frame", 64'(at - t0), 64'd60);
      check("spawn1_en", 64'(bus.en), 64'h1);
      check("spawn1_col_lt640", 64'(bus.control[9:0] < 10'd640), 64'h1);
      check("spawn1_lvlbits", 64'(bus.control[12:11]), 64'h0);
      check("spawn1_hibits", 64'(bus.control[15:13]), 64'h0);
      tick();
      check("pulse_one_cycle", 64'(bus.spawn_pulse), 64'h0);
      wait_pulse(at);
      check("spawn2_frame", 64'(at - t0), 64'd120);
      check("spawn2_en", 64'(bus.en), 64'h3);

      // Pause: 100 frozen edges (99 sampled high plus the PAUSE->RUN edge)
      step_to(t0 + 130);
      bus.pause = 1'b1;
      tick();
      check("pause_en", 64'(bus.en), 64'h0);
      check("pause_busy", 64'(bus.busy), 64'h1);
      step_to(t0 + 229);
      bus.pause = 1'b0;
      tick();
      check("unpause_en", 64'(bus.en), 64'h3);
      wait_pulse(at);
      check("spawn3_frame", 64'(at - t0), 64'd280);
      check("spawn3_en", 64'(bus.en), 64'h7);
      wait_pulse(at);
      check("spawn4_frame", 64'(at - t0), 64'd340);
      check("spawn4_en", 64'(bus.en), 64'hF);

      // Saturation: no further pulses, all slots keep refreshing
      step_to(t0 + 400);
      check("sat_en", 64'(bus.en), 64'hF);
      npulse = 0;
      while (t < t0 + 500) begin
         tick();
         if (bus.spawn_pulse) npulse++;
      end
      check("sat_no_pulse", 64'(npulse), 64'd0);
      snap    = bus.control;
      changed = '0;
      for (int i = 0; i < 4; i++) begin
         prev = bus.control;
         tick();
         for (int k = 0; k < 4; k++)
            if (bus.control[16*k +: 16] != prev[16*k +: 16]) changed[k] = 1'b1;
      end
      for (int k = 0; k < 4; k++) check($sformatf("refresh_slot%0d", k), 64'(changed[k]), 64'h1);
      if (snap == bus.control) check("refresh_any", 64'h0, 64'h1);

      // Difficulty: level_cnt was frozen for 100 frames during the pause
      step_to(t0 + 699);
      check("level_before_1", 64'(bus.level), 64'd0);
      tick();
      check("level_1", 64'(bus.level), 64'd1);

      // Wide instance spawn spacing: 60, 60, 52, 52, 44
      check("dut2_spawns", 64'(p2.size()), 64'd5);
      if (p2.size() >= 5) begin
         check("dut2_gap0", 64'(p2[1] - p2[0]), 64'd60);
         check("dut2_gap1", 64'(p2[2] - p2[1]), 64'd52);
         check("dut2_gap2", 64'(p2[3] - p2[2]), 64'd52);
         check("dut2_gap3", 64'(p2[4] - p2[3]), 64'd44);
      end

      step_to(t0 + 4299);
      check("level_6", 64'(bus.level), 64'd6);
      tick();
      check("level_7", 64'(bus.level), 64'd7);
      for (int k = 0; k < 4; k++)
         check($sformatf("lvl7_bits_slot%0d", k), 64'(bus.control[16*k+11 +: 2]), 64'd3);

      // Game over from RUN; level held in IDLE until the next start
      step_to(t0 + 4310);
      bus.game_over = 1'b1;
      tick();
      bus.game_over = 1'b0;
      check("go_en", 64'(bus.en), 64'h0);
      check("go_busy", 64'(bus.busy), 64'h0);
      check("go_level_held", 64'(bus.level), 64'd7);
      tick();
      bus.game_over = 1'b1;
      tick();
      bus.game_over = 1'b0;
      check("idle_go_busy", 64'(bus.busy), 64'h0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      t1 = t;
      check("restart_level", 64'(bus.level), 64'd0);
      check("restart_en", 64'(bus.en), 64'h0);
      wait_pulse(at);
      check("restart_spawn_frame", 64'(at - t1), 64'd60);
      check("restart_en1", 64'(bus.en), 64'h1);

      // Game over + pause on the frame the timer is at zero
      step_to(t1 + 119);
      bus.pause     = 1'b1;
      bus.game_over = 1'b1;
      tick();
      bus.pause     = 1'b0;
      bus.game_over = 1'b0;
      check("go_win_pulse", 64'(bus.spawn_pulse), 64'h0);
      check("go_win_en", 64'(bus.en), 64'h0);
      check("go_win_busy", 64'(bus.busy), 64'h0);

      // Reset mid-run, then the first-run timing must repeat
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      step_to(t + 30);
      rst = 1'b1;
      tick();
      check("midrst_en", 64'(bus.en), 64'h0);
      check("midrst_level", 64'(bus.level), 64'd0);
      check("midrst_busy", 64'(bus.busy), 64'h0);
      check("midrst_control", bus.control, 64'h0);
      rst = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      t3 = t;
      wait_pulse(at);
      check("postrst_spawn_frame", 64'(at - t3), 64'd60);
      check("postrst_en", 64'(bus.en), 64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/enemy_spawner.md
Name: enemy_spawner

Overview:
Per-frame scheduler that sequences a bank of N enemy sprite instances. It decides when each enemy slot is enabled and drives each slot's 16-bit control word: spawn column, direction flip and speed. It also raises difficulty over time and exposes pause and game-over handling. It sits between the game FSM and the enemy instances, all clocked on frame_clk.

Parameters:
N_ENEMIES, 4, number of enemy slots driven (1..8)
BASE_INTERVAL, 60, frames between spawns at level 0 (8-bit)
MIN_INTERVAL, 16, floor for the spawn interval (8-bit, >=1)
INTERVAL_STEP, 8, interval reduction per level
LEVEL_FRAMES, 600, frames per difficulty level (16-bit)
LFSR_SEED, 16'hACE1, reset value of the LFSR (must be non-zero)

Ports:
frame_clk  in  1  frame-rate clock; only clock
rst  in  1  synchronous, active-high reset
start  in  1  game start request (sampled in IDLE)
pause  in  1  level-sensitive pause
game_over  in  1  stop request; returns to IDLE
en  out  N_ENEMIES  per-slot enable to enemy instances
control  out  16*N_ENEMIES  slot k uses bits [16k+15:16k]
level  out  3  current difficulty level
spawn_pulse  out  1  one-cycle pulse on a slot activation
busy  out  1  high in RUN or PAUSE

Behaviour:
- The only clock is frame_clk. Reset is synchronous and active-high on rst, sampled at the frame_clk edge. All outputs are registered except en and busy, which are decoded from registered state.
- Reset values:
  - State is IDLE. active_mask, control, level, spawn_pulse, level_cnt and refresh_ptr are all 0.
  - lfsr = LFSR_SEED.
  - en = 0 and busy = 0.
- rst mid-operation has the same effect as power-up reset.
- LFSR: 16-bit Galois, mask 16'hB400. It shifts right every frame_clk edge when not in reset, in all states.
- Control word generation (gen): uses the current lfsr value.
  - [9:0] = lfsr[9:0] when < 640, otherwise lfsr[9:0] - 640.
  - [10] = lfsr[10].
  - [12:11] = min(level, 3).
  - [15:13] = 0.
- cur_interval = max(BASE_INTERVAL - level*INTERVAL_STEP, MIN_INTERVAL). Compute it at 9 bits signed so the subtraction cannot wrap.
- FSM:
  - IDLE: en = 0. On start=1, load timer = BASE_INTERVAL-1, clear active_mask, level and level_cnt, then go to RUN.
  - RUN: en = active_mask.
    - game_over=1 takes top priority: clear active_mask, go to IDLE.
    - Else pause=1: go to PAUSE. Nothing else updates in that cycle.
    - Else the timer logic applies:
      - timer != 0: timer decrements.
      - timer == 0 and a free slot exists: set the lowest-index free bit in active_mask, load that slot's control with gen, assert spawn_pulse for that cycle, reload timer = cur_interval-1.
      - timer == 0 and all slots are active: reload the timer with no pulse.
    - Refresh happens on any RUN frame without a spawn. If slot refresh_ptr is active, its control is rewritten with gen. refresh_ptr then increments modulo N_ENEMIES.
    - On a spawn frame, refresh is skipped and refresh_ptr holds.
    - Level counting: level_cnt increments. At LEVEL_FRAMES-1 it wraps to 0 and level increments, saturating at 7.
  - PAUSE: en = 0. timer, level_cnt, active_mask and control are frozen.
    - game_over=1: go to IDLE and clear active_mask.
    - Else pause=0: go to RUN.
- start is ignored outside IDLE. game_over in IDLE has no effect.
- spawn_pulse is high for exactly one cycle per activation and is 0 in every other cycle.
- level stays at its value in IDLE until the next start.

Test Plan:
- Spawn timing: rst, then start=1 for one cycle → spawn_pulse at the 60th RUN edge after entry. en=4'b0001. control[9:0] < 640. control[12:11]=0. The next spawn is 60 frames later with en=4'b0011.
- Saturation: run 300 frames → en=4'b1111. Later timer expiries produce no spawn_pulse. Every control slot still changes within 4 consecutive non-spawn frames (refresh).
- Difficulty ramp: run 600 frames → level=1, subsequent spawn spacing 52 frames. At frame 4200, level=7, spacing clamps to 16, and new control[12:11]=3.
- Pause: assert pause for 100 frames in RUN → en=0 and level_cnt frozen. The next spawn_pulse arrives at the same frame offset it had before the pause, plus 100. Deasserting pause restores en to its previous mask.
- Game over, simultaneous with a pending spawn (timer==0 and pause=1 in the same cycle): game_over wins. State goes to IDLE, en=0, no spawn_pulse. A fresh start resets level to 0.
- Reset mid-run: rst=1 at any RUN frame → on the next edge en=0, level=0, lfsr=16'hACE1, busy=0. A start afterwards repeats the first scenario's timing exactly.
